// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
// Holds the FSM state enum, the slice width and the nibble-count helper.
package nibble_serial_addsub_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int nib_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_addsub_nibble.sv
// addsub_nibble: 4-bit ripple adder slice with explicit carry in/out.
// Ports: a, b (nibbles), cin -> s (nibble sum), cout (carry out).
module addsub_nibble
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);

  logic w_c;

  always_comb begin
    s   = '0;
    w_c = cin;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i] = a[i] ^ b[i] ^ w_c;
      w_c  = (a[i] & b[i]) | (w_c & (a[i] ^ b[i]));
    end
    cout = w_c;
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-cycle WIDTH-bit add/sub that feeds one 4-bit slice per cycle.
// Ports: clk, rst; in_valid/in_ready, a, b, sub in;
// out_valid/out_ready, sum, cout, ovf out; busy high while running.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB  = nib_count(WIDTH);
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(NIB - 1);

  state_t          r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic            r_sub;
  logic            r_carry;
  logic            r_cout;
  logic            r_ovf;
  logic            r_out_valid;
  logic            r_busy;
  logic [IDXW-1:0] r_idx;

  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_s_nib;
  logic                w_c_nib;
  logic                w_cin_msb;
  logic                w_ovf;

  assign w_a_nib = r_a[NIBBLE_W*int'(r_idx) +: NIBBLE_W];
  assign w_b_nib = r_b[NIBBLE_W*int'(r_idx) +: NIBBLE_W]
                   ^ {NIBBLE_W{r_sub}};

  addsub_nibble u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .s    (w_s_nib),
    .cout (w_c_nib)
  );

  // Only meaningful on the top nibble: recover the carry into the
  // sign bit from the sum bit, then compare with the carry out.
  assign w_cin_msb = r_a[WIDTH-1]
                   ^ (r_b[WIDTH-1] ^ r_sub)
                   ^ w_s_nib[NIBBLE_W-1];
  assign w_ovf     = w_cin_msb ^ w_c_nib;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_sum       <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_carry <= sub;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_sum[NIBBLE_W*int'(r_idx) +: NIBBLE_W] <= w_s_nib;
          r_carry <= w_c_nib;
          if (r_idx == LAST) begin
            r_cout      <= w_c_nib;
            r_ovf       <= w_ovf;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
